// File: rtl/bcdu_arbiter_pkg.sv
// rtl/bcdu_arbiter_pkg.sv - shared types and constants for the BCDU instruction-port arbiter
package bcdu_arbiter_pkg;

   localparam int INSTR_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bcdu_arbiter_if.sv
// rtl/bcdu_arbiter_if.sv - requester-side and BCDU-side signals of the arbiter
interface bcdu_arbiter_if #(
   parameter int NUM_REQ = 3
) ();
   import bcdu_arbiter_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [INSTR_WIDTH*NUM_REQ-1:0] instr;
   logic [NUM_REQ-1:0]             instr_valid;
   logic                           bcdu_busy;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             instr_ack;
   logic [INSTR_WIDTH-1:0]         bcdu_instr;
   logic                           bcdu_instr_valid;
   logic [NUM_REQ-1:0]             timeout;

   modport master (
      output req, instr, instr_valid, bcdu_busy,
      input  grant, instr_ack, bcdu_instr, bcdu_instr_valid, timeout
   );

   modport slave (
      input  req, instr, instr_valid, bcdu_busy,
      output grant, instr_ack, bcdu_instr, bcdu_instr_valid, timeout
   );

endinterface

// File: rtl/bcdu_arbiter_rr_priority_select.sv
// rtl/bcdu_arbiter_rr_priority_select.sv - first eligible requester at or after the pointer, wrapping
module rr_priority_select #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   // Scan from the farthest offset down so the nearest eligible one is written last.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eligible[(int'(ptr) + i) % NUM_REQ]) begin
            idx    = IDX_W'((int'(ptr) + i) % NUM_REQ);
            onehot = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcdu_arbiter.sv
// rtl/bcdu_arbiter.sv - round-robin session arbiter for the BCDU instruction port with hold watchdog
module bcdu_arbiter
   import bcdu_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int MAX_HOLD   = 256,
   parameter int HOLD_WIDTH = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input logic           i_clk,
   input logic           i_rst,
   bcdu_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t              state, state_nxt;
   logic [NUM_REQ-1:0]      grant, grant_nxt;
   logic [NUM_REQ-1:0]      mask, mask_nxt;
   logic [NUM_REQ-1:0]      timeout, timeout_nxt;
   logic [IDX_W-1:0]        ptr, ptr_nxt;
   logic [IDX_W-1:0]        owner, owner_nxt;
   logic [HOLD_WIDTH-1:0]   hold, hold_nxt;

   logic [NUM_REQ-1:0]      eligible;
   logic [NUM_REQ-1:0]      sel_onehot;
   logic [IDX_W-1:0]        sel_idx;
   logic                    sel_valid;
   logic                    accept;
   logic                    hold_expired;

   assign eligible = bus.req & ~mask;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_select (
      .eligible (eligible),
      .ptr      (ptr),
      .onehot   (sel_onehot),
      .idx      (sel_idx),
      .valid    (sel_valid)
   );

   assign accept       = (state == ST_GRANT) && bus.instr_valid[owner] && !bus.bcdu_busy;
   assign hold_expired = (MAX_HOLD != 0) && (hold == HOLD_WIDTH'(MAX_HOLD - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         grant   <= '0;
         mask    <= '0;
         timeout <= '0;
         ptr     <= '0;
         owner   <= '0;
         hold    <= '0;
      end else begin
         state   <= state_nxt;
         grant   <= grant_nxt;
         mask    <= mask_nxt;
         timeout <= timeout_nxt;
         ptr     <= ptr_nxt;
         owner   <= owner_nxt;
         hold    <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      owner_nxt   = owner;
      ptr_nxt     = ptr;
      hold_nxt    = hold;
      timeout_nxt = '0;
      // A revoked requester becomes eligible again only after it lets go once.
      mask_nxt    = mask & bus.req;
      case (state)
         ST_IDLE: begin
            if (sel_valid) begin
               state_nxt = ST_GRANT;
               grant_nxt = sel_onehot;
               owner_nxt = sel_idx;
               ptr_nxt   = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
               hold_nxt  = '0;
            end
         end
         ST_GRANT: begin
            hold_nxt = hold + 1'b1;
            if (!bus.req[owner]) begin
               state_nxt = ST_DRAIN;
               grant_nxt = '0;
            end else if (hold_expired) begin
               state_nxt          = ST_DRAIN;
               grant_nxt          = '0;
               mask_nxt[owner]    = 1'b1;
               timeout_nxt[owner] = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (!bus.bcdu_busy) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign bus.grant            = grant;
   assign bus.timeout          = timeout;
   assign bus.bcdu_instr_valid = accept;
   assign bus.bcdu_instr       = accept ? bus.instr[owner*INSTR_WIDTH +: INSTR_WIDTH] : '0;
   assign bus.instr_ack        = accept ? grant : '0;

endmodule
